uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART byte receiver/transmitter and the arithmetic core.
//  - Assembles framed requests from received bytes: sync, opcode, operand A, operand B.
//  - Issues each request to the core, waits for completion, then streams the result back byte-serially.
//  - Owns frame timeout and bad-opcode error handling; one command in flight at a time.
// PARAMETERS
//  CLK_FREQ      125_000_000  clock frequency, Hz
//  OP_BYTES      4            bytes per operand; operand width = 8*OP_BYTES
//  RES_BYTES     8            bytes per result; result width = 8*RES_BYTES
//  NUM_OPS       4            valid opcodes are 0..NUM_OPS-1
//  SYNC_BYTE     8'hA5        frame start marker
//  ERR_BYTE      8'hEE        single-byte reply to an invalid opcode
//  TIMEOUT_CLKS  CLK_FREQ/100 max idle clocks between bytes inside a frame (10 ms)
// PORTS
//  iClk       in   1            clock
//  iRst       in   1            synchronous, active-high reset
//  iRxByte    in   8            received byte, valid when iRxDone=1
//  iRxDone    in   1            1-cycle pulse, byte received
//  oTxStart   out  1            1-cycle pulse, transmit oTxByte
//  oTxByte    out  8            byte to transmit, held stable until iTxDone
//  iTxBusy    in   1            transmitter busy
//  iTxDone    in   1            1-cycle pulse, byte transmitted
//  oOpStart   out  1            1-cycle pulse, start arithmetic operation
//  oOpcode    out  8            opcode, stable from oOpStart until iOpDone
//  oOperandA  out  8*OP_BYTES   operand A, stable from oOpStart until iOpDone
//  oOperandB  out  8*OP_BYTES   operand B, stable from oOpStart until iOpDone
//  iOpDone    in   1            1-cycle pulse, iResult valid
//  iResult    in   8*RES_BYTES  result, sampled on iOpDone
//  oBusy      out  1            1 in every state except sIDLE
//  oErr       out  1            1-cycle pulse on timeout or bad opcode
// BEHAVIOUR
//  Reset: state=sIDLE; all outputs 0; operand/result/byte counters and timeout counter = 0.
//  Frame: SYNC_BYTE, opcode, A[MSB byte first], B[MSB byte first]. Total 2+2*OP_BYTES bytes.
//  States and transitions:
//   sIDLE : on iRxDone with iRxByte==SYNC_BYTE -> sOPC. Any other byte is discarded.
//   sOPC  : on iRxDone: latch opcode. Opcode<NUM_OPS -> sOPA; otherwise pulse oErr -> sTXL with ERR_BYTE, count=1.
//   sOPA  : on iRxDone: shift-left the byte into A. After OP_BYTES bytes -> sOPB.
//   sOPB  : same as sOPA for B. After OP_BYTES bytes -> sISSUE.
//   sISSUE: pulse oOpStart for one cycle -> sWAIT.
//   sWAIT : on iOpDone: latch iResult -> sTXL, count=RES_BYTES.
//   sTXL  : when iTxBusy==0: pulse oTxStart with oTxByte = current MS result byte (or ERR_BYTE) -> sTXW.
//   sTXW  : on iTxDone: decrement count, shift result left by 8. count==0 -> sIDLE; else -> sTXL.
//  Latencies:
//   - Last B byte to oOpStart: 2 cycles (sOPB->sISSUE, then pulse).
//   - iOpDone to first oTxStart: 1 cycle when iTxBusy=0.
//   - iTxDone to next oTxStart: 1 cycle when iTxBusy=0.
//  Timeout: applies only in sOPC/sOPA/sOPB.
//   - Counter clears on entry and on every iRxDone.
//   - Reaching TIMEOUT_CLKS-1 pulses oErr and goes to sIDLE with no reply.
//   - iRxDone in the same cycle as expiry: the byte wins and the counter clears.
//  Ignored inputs:
//   - iRxDone in sISSUE/sWAIT/sTXL/sTXW: byte dropped (no queuing).
//   - iOpDone outside sWAIT: ignored.
//   - iTxDone outside sTXW: ignored.
//  A SYNC_BYTE arriving mid-frame is data, not a resync.
//  Reset mid-operation: immediate return to reset state; a pending core/tx op is abandoned.
//  Width: byte counter $clog2(max(OP_BYTES,RES_BYTES)+1) bits; timeout counter $clog2(TIMEOUT_CLKS+1) bits.
// STRUCTURE
//  Shared package uart_acc_pkg:
//   - state localparams;
//   - SYNC_BYTE, ERR_BYTE;
//   - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_CMP=3.
//  Single FSM with registered-current/combinational-next split.
//  One sub-module: cmd_timeout_cnt (clear, enable, expire pulse), reusable by the tx path.
// TESTING
//  1. A5,00,00000005,00000003 -> oOpStart once, A=5, B=3, opcode 0; iResult=8 -> 8 tx bytes 00..00,08.
//  2. Bad opcode: A5,07 -> oErr pulse, exactly one tx byte EE, back to sIDLE, oBusy=0.
//  3. Timeout: A5,01 then TIMEOUT_CLKS idle -> oErr, sIDLE, no oOpStart, no tx.
//  4. Garbage 12,34 then a valid frame -> garbage ignored, result for the valid frame only.
//  5. Bytes during sWAIT, iTxBusy held high 50 cycles -> bytes dropped, first oTxStart 1 cycle after busy falls.
//  6. iRst asserted in sOPB and in sTXW -> all outputs 0 next cycle, new frame processes normally.

Source files
------------

// File: rtl/uart_acc_pkg.sv
// Shared types and constants for the UART accelerator command path.
package uart_acc_pkg;

  typedef enum logic [2:0] {
    sIDLE  = 3'd0,
    sOPC   = 3'd1,
    sOPA   = 3'd2,
    sOPB   = 3'd3,
    sISSUE = 3'd4,
    sWAIT  = 3'd5,
    sTXL   = 3'd6,
    sTXW   = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;

  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_MUL = 8'd2;
  localparam logic [7:0] OP_CMP = 8'd3;

  function automatic logic opcode_ok(input logic [7:0] opc, input int unsigned num_ops);
    return ({24'd0, opc} < num_ops);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout_cnt.sv
// Idle-clock watchdog: counts enabled cycles since the last clear and pulses expire
// on the cycle the count reaches LIMIT-1, unless a clear arrives in that same cycle.
module cmd_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_limit;

  assign at_limit = (cnt_q == W'(LIMIT - 1));
  assign expire_o = en_i && !clr_i && at_limit;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || at_limit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: frames received bytes into core requests, issues them, and
// streams the result (or a single error byte) back to the transmitter.
module uart_cmd_ctrl #(
  parameter int unsigned CLK_FREQ     = 125_000_000,
  parameter int unsigned OP_BYTES     = 4,
  parameter int unsigned RES_BYTES    = 8,
  parameter int unsigned NUM_OPS      = 4,
  parameter logic [7:0]  SYNC_BYTE    = uart_acc_pkg::SYNC_BYTE,
  parameter logic [7:0]  ERR_BYTE     = uart_acc_pkg::ERR_BYTE,
  parameter int unsigned TIMEOUT_CLKS = CLK_FREQ / 100
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic [7:0]             iRxByte,
  input  logic                   iRxDone,
  output logic                   oTxStart,
  output logic [7:0]             oTxByte,
  input  logic                   iTxBusy,
  input  logic                   iTxDone,
  output logic                   oOpStart,
  output logic [7:0]             oOpcode,
  output logic [8*OP_BYTES-1:0]  oOperandA,
  output logic [8*OP_BYTES-1:0]  oOperandB,
  input  logic                   iOpDone,
  input  logic [8*RES_BYTES-1:0] iResult,
  output logic                   oBusy,
  output logic                   oErr
);

  import uart_acc_pkg::*;

  localparam int unsigned OP_W  = 8 * OP_BYTES;
  localparam int unsigned RES_W = 8 * RES_BYTES;
  localparam int unsigned MAX_B = (OP_BYTES > RES_BYTES) ? OP_BYTES : RES_BYTES;
  localparam int unsigned CNT_W = $clog2(MAX_B + 1);

  state_e           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d, txbyte_q, txbyte_d;
  logic [OP_W-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [RES_W-1:0] res_q, res_d, res_shl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             opstart_q, opstart_d, txstart_q, txstart_d, err_q, err_d;
  logic             to_en, to_expire;

  assign to_en   = (state_q == sOPC) || (state_q == sOPA) || (state_q == sOPB);
  assign res_shl = res_q << 8;

  cmd_timeout_cnt #(.LIMIT(TIMEOUT_CLKS)) u_timeout (
    .iClk    (iClk),
    .iRst    (iRst),
    .clr_i   (iRxDone),
    .en_i    (to_en),
    .expire_o(to_expire)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    txbyte_d  = txbyte_q;
    opstart_d = 1'b0;
    txstart_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      sIDLE: begin
        if (iRxDone && (iRxByte == SYNC_BYTE)) begin
          state_d = sOPC;
        end else begin
          state_d = sIDLE;
        end
      end
      sOPC: begin
        if (iRxDone) begin
          opcode_d = iRxByte;
          cnt_d    = '0;
          if (opcode_ok(iRxByte, NUM_OPS)) begin
            state_d = sOPA;
          end else begin
            err_d   = 1'b1;
            res_d   = {ERR_BYTE, {(RES_W-8){1'b0}}};
            cnt_d   = CNT_W'(1);
            state_d = sTXL;
          end
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = sIDLE;
        end else begin
          state_d = sOPC;
        end
      end
      sOPA: begin
        if (iRxDone) begin
          opa_d = (opa_q << 8) | OP_W'(iRxByte);
          if (cnt_q == CNT_W'(OP_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = sOPB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = sIDLE;
        end else begin
          state_d = sOPA;
        end
      end
      sOPB: begin
        if (iRxDone) begin
          opb_d = (opb_q << 8) | OP_W'(iRxByte);
          if (cnt_q == CNT_W'(OP_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = sISSUE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = sIDLE;
        end else begin
          state_d = sOPB;
        end
      end
      sISSUE: begin
        opstart_d = 1'b1;
        state_d   = sWAIT;
      end
      // An idle transmitter lets the first byte launch straight from sWAIT.
      sWAIT: begin
        if (iOpDone) begin
          res_d = iResult;
          cnt_d = CNT_W'(RES_BYTES);
          if (!iTxBusy) begin
            txstart_d = 1'b1;
            txbyte_d  = iResult[RES_W-1 -: 8];
            state_d   = sTXW;
          end else begin
            state_d = sTXL;
          end
        end else begin
          state_d = sWAIT;
        end
      end
      sTXL: begin
        if (!iTxBusy) begin
          txstart_d = 1'b1;
          txbyte_d  = res_q[RES_W-1 -: 8];
          state_d   = sTXW;
        end else begin
          state_d = sTXL;
        end
      end
      sTXW: begin
        if (iTxDone) begin
          res_d = res_shl;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = sIDLE;
          end else if (!iTxBusy) begin
            txstart_d = 1'b1;
            txbyte_d  = res_shl[RES_W-1 -: 8];
            state_d   = sTXW;
          end else begin
            state_d = sTXL;
          end
        end else begin
          state_d = sTXW;
        end
      end
      default: begin
        state_d = sIDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= sIDLE;
      opcode_q  <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      txbyte_q  <= '0;
      opstart_q <= 1'b0;
      txstart_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      txbyte_q  <= txbyte_d;
      opstart_q <= opstart_d;
      txstart_q <= txstart_d;
      err_q     <= err_d;
    end
  end

  assign oTxStart  = txstart_q;
  assign oTxByte   = txbyte_q;
  assign oOpStart  = opstart_q;
  assign oOpcode   = opcode_q;
  assign oOperandA = opa_q;
  assign oOperandB = opb_q;
  assign oErr      = err_q;
  assign oBusy     = (state_q != sIDLE);

endmodule
